fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the single-cycle core. Owns the PC, issues
//  req/gnt requests to instruction memory, waits for rvalid, holds the fetched
//  word for decode (valid/ready). Accepts a redirect (taken branch target
//  pc+imm from the datapath) and squashes any in-flight fetch.
// PARAMETERS
//  XLEN      64  PC / address width
//  ILEN      32  instruction width
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clk             in   1     clock, rising edge
//  reset_n         in   1     asynchronous, active-low reset
//  start           in   1     leave IDLE and begin fetching
//  imem_req        out  1     fetch request valid
//  imem_addr       out  XLEN  fetch address (= pc)
//  imem_gnt        in   1     request accepted this cycle
//  imem_rvalid     in   1     read data valid
//  imem_rdata      in   ILEN  read data
//  inst_valid      out  1     fetched instruction valid to decode
//  inst_data       out  ILEN  fetched instruction
//  inst_pc         out  XLEN  PC of inst_data
//  inst_ready      in   1     decode accepts instruction
//  redirect_valid  in   1     taken branch / jump, 1-cycle pulse
//  redirect_pc     in   XLEN  branch target; bits [1:0] forced to 0
//  perf_wait_cnt   out  32    FETCH_PERF_EN only
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, squash=0, imem_req=0, inst_valid=0,
//   inst_data=0, inst_pc=0. Reset mid-operation aborts immediately; imem must
//   be reset together (no stale rvalid after reset).
//  States: IDLE, REQ, WAIT, HOLD. imem_req=1 only in REQ; inst_valid=1 only in HOLD.
//  IDLE: start=1 -> REQ. redirect_valid in IDLE loads pc, stays IDLE.
//  REQ: imem_addr=pc, held stable while req&!gnt unless redirect. gnt -> WAIT.
//   redirect w/o gnt: pc<=redirect_pc, stay REQ (addr changes next cycle).
//   redirect with gnt: squash<=1, pc<=redirect_pc, -> WAIT.
//  WAIT: rvalid&!squash&!redirect: inst_data<=rdata, inst_pc<=pc,
//   pc<=pc+4, -> HOLD. rvalid&(squash|redirect): drop data, squash<=0,
//   -> REQ. redirect w/o rvalid: squash<=1, pc<=redirect_pc, stay WAIT.
//  HOLD: inst_* stable until inst_ready. inst_ready -> REQ. redirect (with
//   or without inst_ready): pc<=redirect_pc, inst_valid<=0, -> REQ.
//  Redirect always wins over increment; at most one outstanding request.
//  pc+4 wraps modulo 2^XLEN. Zero-wait memory (gnt in REQ, rvalid next
//   cycle), inst_ready=1: 3 cycles/instruction.
// CONFIGURATION
//  FETCH_PERF_EN defined: perf_wait_cnt counts cycles in REQ&!gnt or
//   WAIT&!rvalid; saturates at 2^32-1; cleared by reset.
//  Not defined: port perf_wait_cnt and counter absent.
// STRUCTURE
//  fetch_pkg: state typedef fetch_state_t {IDLE,REQ,WAIT,HOLD}; PC_INCR=4.
//  Sub-module fetch_pc_next: combinational next-pc mux (hold / +4 / redirect
//   with [1:0] clear); PC register stays in fetch_sequencer.
// TESTING
//  1 reset_n low mid-WAIT -> next cycle IDLE, imem_req=0, inst_valid=0, pc=RESET_PC.
//  2 start, gnt at once, rvalid next cycle rdata=0x00A00093, ready=1 ->
//    inst_pc=0,4,8 on successive HOLD cycles, 3 cycles apart.
//  3 gnt held low 5 cycles -> imem_req=1, imem_addr const 5 cycles;
//    perf_wait_cnt=5 (FETCH_PERF_EN).
//  4 redirect_pc=0x100 while in WAIT for addr 0x8 -> rvalid data dropped, next
//    imem_addr=0x100, inst_pc=0x100.
//  5 HOLD with inst_ready=0 and redirect_pc=0x203 -> inst_valid=0 next cycle,
//    imem_addr=0x200.
//  6 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - next-pc select: hold, sequential increment, or word-aligned redirect
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic            incr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_next
);

  // A redirect outranks the increment so a taken branch is never lost.
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (incr) begin
      pc_next = pc + XLEN'(PC_INCR);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and req/gnt/rvalid fetch FSM with decode hand-off
// Optional stall counter perf_wait_cnt is built only when FETCH_PERF_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_wait_cnt
`endif
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            squash, squash_next;
  logic            incr;
  logic            capture;

  fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc             (pc),
    .incr           (incr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_next        (pc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      squash <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      squash <= squash_next;
    end
  end

  // squash marks the single outstanding response as belonging to a stale path.
  always_comb begin
    state_next  = state;
    squash_next = squash;
    incr        = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          state_next = WAIT;
          if (redirect_valid) squash_next = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          squash_next = 1'b0;
          if (squash || redirect_valid) begin
            state_next = REQ;
          end else begin
            capture    = 1'b1;
            incr       = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect_valid) begin
          squash_next = 1'b1;
        end
      end
      HOLD: begin
        if (inst_ready || redirect_valid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_data <= '0;
      inst_pc   <= '0;
    end else if (capture) begin
      inst_data <= imem_rdata;
      inst_pc   <= pc;
    end
  end

  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = ((state == REQ) && !imem_gnt) || ((state == WAIT) && !imem_rvalid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_wait_cnt <= '0;
    end else if (stall && (perf_wait_cnt != '1)) begin
      perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized self-checking bench for fetch_sequencer
// Checks perf_wait_cnt as well when FETCH_PERF_EN is defined.
module tb_fetch_sequencer;

  localparam int          XLEN   = 64;
  localparam int          ILEN   = 32;
  localparam logic [63:0] RST_PC = 64'h0;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [ILEN-1:0] imem_rdata = '0;
  logic            inst_valid;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_wait_cnt;
`endif

  fetch_sequencer #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  // Memory responder: one outstanding read, configurable grant rate and latency.
  int          gnt_pct = 100;
  int          lat_lo = 0;
  int          lat_hi = 0;
  bit          gnt_block = 1'b0;
  bit          data_fixed = 1'b0;
  logic [31:0] fixed_word = '0;
  bit          outstanding = 1'b0;
  logic [63:0] out_addr = '0;
  int          lat_left = 0;

  always @(negedge clk) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (!reset_n) begin
      outstanding = 1'b0;
    end else begin
      if (outstanding) begin
        if (lat_left == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = data_fixed ? fixed_word : mem_word(out_addr);
          outstanding = 1'b0;
        end else begin
          lat_left--;
        end
      end
      if (imem_req && !outstanding && !gnt_block && ($urandom_range(99) < gnt_pct)) begin
        imem_gnt    = 1'b1;
        outstanding = 1'b1;
        out_addr    = imem_addr;
        lat_left    = $urandom_range(lat_hi, lat_lo);
      end
    end
  end

  task automatic wait_sig(input string tag, input bit want_req, input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_req ? imem_req : inst_valid) && n < bound);
    check(tag, want_req ? imem_req : inst_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_pc;
    int          last_cyc;
    int          delivered;
    exp_pc = '0;
    last_cyc = 0;
    delivered = 0;
    reset_n = 1'b0;
    start = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_data", inst_data, 0);
    check("rst_ipc", inst_pc, 0);
`ifdef FETCH_PERF_EN
    check("rst_perf", perf_wait_cnt, 0);
`endif

    // Reset in the middle of WAIT aborts back to IDLE at RESET_PC.
    reset_n = 1'b1;
    lat_lo = 4;
    lat_hi = 4;
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("idle_redirect_addr", imem_addr, 64'h40);
    check("idle_no_req", imem_req, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_req", imem_req, 1);
    @(negedge clk);
    check("t1_wait_no_req", imem_req, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("t1_req_after_rst", imem_req, 0);
    check("t1_valid_after_rst", inst_valid, 0);
    check("t1_addr_after_rst", imem_addr, RST_PC);
    gnt_block = 1'b1;

    // Grant withheld for five cycles: request and address stay put.
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("t3_req_held", imem_req, 1);
      check("t3_addr_held", imem_addr, RST_PC);
    end
    #1;
    gnt_block = 1'b0;
    lat_lo = 0;
    lat_hi = 0;
    data_fixed = 1'b1;
    fixed_word = 32'h00A0_0093;
    inst_ready = 1'b1;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    check("t3_perf", perf_wait_cnt, 5);
`endif

    // Zero-wait memory: one instruction every three cycles.
    for (int k = 0; k < 3; k++) begin
      wait_sig("t2_valid", 1'b0, 12);
      check("t2_pc", inst_pc, 64'(4 * k));
      check("t2_data", inst_data, 32'h00A0_0093);
      if (k != 0) check("t2_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
    end
    inst_ready = 1'b0;

    // Redirect while HOLD without ready drops the held word.
    @(negedge clk);
    check("t5_hold_valid", inst_valid, 1);
    check("t5_hold_pc", inst_pc, 64'h8);
    redirect_valid = 1'b1;
    redirect_pc = 64'h203;
    lat_lo = 3;
    lat_hi = 3;
    data_fixed = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t5_valid_drop", inst_valid, 0);
    check("t5_req", imem_req, 1);
    check("t5_addr", imem_addr, 64'h200);

    // Redirect during WAIT squashes the in-flight response.
    @(negedge clk);
    check("t4_wait_no_req", imem_req, 0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_sig("t4_req", 1'b1, 12);
    check("t4_addr", imem_addr, 64'h100);
    wait_sig("t4_valid", 1'b0, 12);
    check("t4_pc", inst_pc, 64'h100);
    check("t4_data", inst_data, mem_word(64'h100));

    // Fetch from the top of the address space wraps to zero.
    lat_lo = 0;
    lat_hi = 0;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_sig("t6_valid", 1'b0, 12);
    check("t6_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_sig("t6_req", 1'b1, 12);
    check("t6_wrap_addr", imem_addr, 64'h0);

    // Random traffic against a program-order model of delivered instructions.
    gnt_pct = 60;
    lat_lo = 0;
    lat_hi = 3;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      inst_ready = (c == 0) ? 1'b0 : ($urandom_range(99) < 70);
      redirect_valid = (c == 0) || ($urandom_range(99) < 4);
      redirect_pc = {$urandom, $urandom};
      if (inst_valid && inst_ready) begin
        check("rnd_pc", inst_pc, exp_pc);
        check("rnd_data", inst_data, mem_word(exp_pc));
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
    end
    redirect_valid = 1'b0;
    check("rnd_progress", delivered > 200, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
